if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core. It holds the PC, drives the instruction-memory address and registers the fetched word into the IF/ID register. It consumes the decode-stage PCSrc encoding and the EX-stage branch outcome to select the next PC. It also latches and masks the external interrupt and produces the IRQ input of the decode control unit.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset (kernel mode)
IRQ_VEC, 32'h80000004, interrupt handler address
EXC_VEC, 32'h80000008, undefined-instruction handler address

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-low reset
imem_addr  out  32  current PC to instruction memory (combinational read)
imem_rdata  in  32  instruction at imem_addr, same cycle
stall  in  1  load-use hazard; hold PC and IF/ID
id_pcsrc  in  3  PCSrc of the instruction in ID (000 seq, 001 branch, 010 j/jal, 011 jr/jalr, 100 irq, 101 exception)
jr_target  in  32  forwarded rs value for jr/jalr
ex_branch_taken  in  1  branch in EX resolved taken
ex_branch_target  in  32  branch target from EX
irq  in  1  external interrupt request, level, synchronous to clk
irq_take  out  1  to control IRQ input; take interrupt on ID instruction
if_id_pc  out  32  PC of instruction in ID (EPC source when irq/exception)
if_id_pc_plus4  out  32  PC+4 of instruction in ID (link value)
if_id_instr  out  32  instruction in ID; 0 (nop) when bubble
if_id_valid  out  1  ID holds a real instruction
flush_id_ex  out  1  kill the instruction entering EX (branch taken)

Behaviour:
- Reset (reset==0 at a rising edge): pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, irq_pending=0. Outputs follow these registers.
- pc_plus4 = {pc[31], pc[30:0]+4}. The kernel bit PC[31] is preserved on sequential fetch and wraps within the 31-bit field.
- Jump target = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}.
- Next-PC priority (highest first), evaluated every cycle:
  1. ex_branch_taken: pc<=ex_branch_target; IF/ID<=bubble; flush_id_ex=1. Overrides stall and every ID-stage redirect.
  2. stall: pc and IF/ID hold. irq_take=0.
  3. if_id_valid and id_pcsrc==100: pc<=IRQ_VEC; IF/ID<=bubble; irq_pending cleared.
  4. if_id_valid and id_pcsrc==101: pc<=EXC_VEC; IF/ID<=bubble.
  5. if_id_valid and id_pcsrc==010: pc<=jump target; IF/ID<=bubble.
  6. if_id_valid and id_pcsrc==011: pc<=jr_target; IF/ID<=bubble. PC[31] comes from jr_target, which is how the kernel exits.
  7. otherwise, including id_pcsrc 000 or 001: pc<=pc_plus4; IF/ID<={pc, pc_plus4, imem_rdata, valid=1}.
- Branches resolve in EX, so a branch incurs a 2-instruction penalty. Jumps resolve in ID and incur a 1-instruction penalty. There are no delay slots.
- Bubble: if_id_instr=0 (sll $0,$0,0), if_id_valid=0. With id_pcsrc ignored when !if_id_valid, a bubble never redirects.
- Interrupt:
  - irq_pending is set on any cycle with irq==1.
  - irq_take = irq_pending & if_id_valid & ~if_id_pc[31] & ~stall & ~ex_branch_taken.
  - Interrupts are masked in kernel mode and on bubbles. irq_pending remains set until taken.
  - The interrupted ID instruction is discarded. Its PC (if_id_pc) is the EPC, so it re-executes after the return.
- id_pcsrc is combinationally dependent on irq_take through control. if_stage must not route id_pcsrc back into irq_take, so no combinational loop exists.
- Reset mid-operation overrides all inputs. No pending redirect or interrupt survives reset.

Decomposition:
- Shared package cpu_defs: PCSRC_SEQ/BRANCH/JUMP/JR/IRQ/EXC 3-bit constants (shared with control), RESET_PC/IRQ_VEC/EXC_VEC values, NOP_INSTR=32'h0.
- One sub-module is natural: if_id_reg. It holds the pipeline register with load, hold (stall) and bubble (flush) controls.
- The next-PC mux and IRQ latch stay in if_stage.

Test Plan:
- Reset then 3 free cycles (imem returns 32'h20080001...) -> imem_addr 80000000, 80000004, 80000008; if_id_valid rises in cycle 2 with if_id_pc=80000000.
- j with if_id_instr=32'h08000010, if_id_pc_plus4=00400008, id_pcsrc=010 -> next imem_addr=00000040, IF/ID bubble (instr=0, valid=0) for one cycle.
- ex_branch_taken=1, target=00400100, with stall=1 and id_pcsrc=010 the same cycle -> pc=00400100, flush_id_ex=1, IF/ID bubble; jump ignored.
- stall held 2 cycles at pc=00400010 -> imem_addr and all if_id_* unchanged both cycles; pc=00400014 on release.
- irq pulsed 1 cycle while if_id_pc=80000020 -> irq_take=0; after jr to 00400000 (PC[31]=0) with valid ID, irq_take=1, control returns 100, pc<=80000004, if_id_pc seen as EPC=00400000.
- irq pending, id_pcsrc=101 on undefined opcode in kernel mode (if_id_pc=80000010) -> pc=80000008, irq_take=0, irq_pending still 1.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared core definitions: PCSrc encodings (common with the decode control
// unit), fixed vector addresses and the IF/ID pipeline register layout.
package cpu_defs;

    localparam logic [2:0] PCSRC_SEQ    = 3'b000;
    localparam logic [2:0] PCSRC_BRANCH = 3'b001;
    localparam logic [2:0] PCSRC_JUMP   = 3'b010;
    localparam logic [2:0] PCSRC_JR     = 3'b011;
    localparam logic [2:0] PCSRC_IRQ    = 3'b100;
    localparam logic [2:0] PCSRC_EXC    = 3'b101;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage.
// Protocol: no valid/ready; the fetch stage always presents imem_addr and the
// memory returns imem_rdata combinationally in the same cycle.
interface if_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble beats load, load beats hold; a bubble is a
// cleared entry, which leaves a nop in ID that never redirects the PC.
module if_id_reg
    import cpu_defs::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load_i,
    input  logic   bubble_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= '{pc: 32'h0, pc_plus4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
        end else if (bubble_i) begin
            q_q <= '{pc: 32'h0, pc_plus4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// the latched external interrupt request presented to decode control.
module if_stage #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter logic [31:0] IRQ_VEC  = cpu_defs::IRQ_VEC,
    parameter logic [31:0] EXC_VEC  = cpu_defs::EXC_VEC
) (
    input  logic              clk,
    input  logic              reset,
    if_stage_if.master        imem,
    input  logic              stall,
    input  logic [2:0]        id_pcsrc,
    input  logic [31:0]       jr_target,
    input  logic              ex_branch_taken,
    input  logic [31:0]       ex_branch_target,
    input  logic              irq,
    output logic              irq_take,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_pc_plus4,
    output logic [31:0]       if_id_instr,
    output logic              if_id_valid,
    output logic              flush_id_ex,
    output logic              dbg_irq_pending_o
);

    logic [31:0]      pc_q, pc_d;
    logic             irq_pending_q, irq_pending_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      jump_target;
    logic             id_load, id_bubble, irq_clear;
    cpu_defs::if_id_t id_d, id_q;

    // Kernel bit is sticky on sequential fetch; the low 31 bits wrap.
    assign pc_plus4    = {pc_q[31], pc_q[30:0] + 31'd4};
    assign jump_target = {id_q.pc_plus4[31:28], id_q.instr[25:0], 2'b00};

    always_comb begin
        pc_d      = pc_q;
        id_load   = 1'b0;
        id_bubble = 1'b0;
        irq_clear = 1'b0;
        if (ex_branch_taken) begin
            pc_d      = ex_branch_target;
            id_bubble = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (id_q.valid && id_pcsrc == cpu_defs::PCSRC_IRQ) begin
            pc_d      = IRQ_VEC;
            id_bubble = 1'b1;
            irq_clear = 1'b1;
        end else if (id_q.valid && id_pcsrc == cpu_defs::PCSRC_EXC) begin
            pc_d      = EXC_VEC;
            id_bubble = 1'b1;
        end else if (id_q.valid && id_pcsrc == cpu_defs::PCSRC_JUMP) begin
            pc_d      = jump_target;
            id_bubble = 1'b1;
        end else if (id_q.valid && id_pcsrc == cpu_defs::PCSRC_JR) begin
            pc_d      = jr_target;
            id_bubble = 1'b1;
        end else begin
            pc_d    = pc_plus4;
            id_load = 1'b1;
        end
    end

    // A new request in the same cycle as the take keeps the latch set.
    assign irq_pending_d = (irq_pending_q & ~irq_clear) | irq;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            irq_pending_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            irq_pending_q <= irq_pending_d;
        end
    end

    assign id_d = '{pc: pc_q, pc_plus4: pc_plus4, instr: imem.imem_rdata, valid: 1'b1};

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load_i   (id_load),
        .bubble_i (id_bubble),
        .d_i      (id_d),
        .q_o      (id_q)
    );

    // id_pcsrc is deliberately absent here: control derives it from irq_take.
    assign irq_take = irq_pending_q & id_q.valid & ~id_q.pc[31] & ~stall & ~ex_branch_taken;

    assign imem.imem_addr    = pc_q;
    assign if_id_pc          = id_q.pc;
    assign if_id_pc_plus4    = id_q.pc_plus4;
    assign if_id_instr       = id_q.instr;
    assign if_id_valid       = id_q.valid;
    assign flush_id_ex       = ex_branch_taken;
    assign dbg_irq_pending_o = irq_pending_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model of the fetch rules.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  id_pcsrc;
    logic [31:0] jr_target;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        irq;
    logic        irq_take;
    logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
    logic        if_id_valid, flush_id_ex, dbg_irq_pending;

    if_stage_if imem_bus ();

    if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .imem              (imem_bus),
        .stall             (stall),
        .id_pcsrc          (id_pcsrc),
        .jr_target         (jr_target),
        .ex_branch_taken   (ex_branch_taken),
        .ex_branch_target  (ex_branch_target),
        .irq               (irq),
        .irq_take          (irq_take),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_instr       (if_id_instr),
        .if_id_valid       (if_id_valid),
        .flush_id_ex       (flush_id_ex),
        .dbg_irq_pending_o (dbg_irq_pending)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_instr;
    logic        m_id_valid, m_pend;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2008_0001 + ((a >> 2) & 32'h0000_0fff);
    endfunction

    function automatic logic [31:0] seq_next(input logic [31:0] a);
        return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7fff_ffff);
    endfunction

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_id_pc = 0; m_id_pc4 = 0; m_id_instr = 0;
        m_id_valid = 0; m_pend = 0;
    endtask

    task automatic model_bubble();
        m_id_pc = 0; m_id_pc4 = 0; m_id_instr = 0; m_id_valid = 0;
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input bit rst_n, input bit st, input bit br, input logic [31:0] btgt,
                        input logic [2:0] src, input logic [31:0] jr, input bit irq_in,
                        input logic [31:0] instr);
        bit          exp_take;
        logic [2:0]  eff_src;
        logic [31:0] n_pc;
        bit          n_pend;
        exp_take = m_pend && m_id_valid && !m_id_pc[31] && !st && !br;
        eff_src  = exp_take ? 3'b100 : src;   // control answers irq_take with PCSrc=irq
        reset = rst_n; stall = st; ex_branch_taken = br; ex_branch_target = btgt;
        id_pcsrc = eff_src; jr_target = jr; irq = irq_in; imem_bus.imem_rdata = instr;
        #1;
        check("imem_addr", imem_bus.imem_addr, m_pc);
        check("if_id_pc", if_id_pc, m_id_pc);
        check("if_id_pc_plus4", if_id_pc_plus4, m_id_pc4);
        check("if_id_instr", if_id_instr, m_id_instr);
        check("if_id_valid", 32'(if_id_valid), 32'(m_id_valid));
        check("irq_take", 32'(irq_take), 32'(exp_take));
        check("flush_id_ex", 32'(flush_id_ex), 32'(br));
        check("irq_pending", 32'(dbg_irq_pending), 32'(m_pend));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            n_pend = m_pend || irq_in;
            n_pc   = m_pc;
            if (br) begin
                n_pc = btgt; model_bubble();
            end else if (st) begin
                n_pc = m_pc;
            end else if (m_id_valid && eff_src inside {3'b100, 3'b101, 3'b010, 3'b011}) begin
                case (eff_src)
                    3'b100: begin n_pc = 32'h8000_0004; n_pend = irq_in; end
                    3'b101: n_pc = 32'h8000_0008;
                    3'b010: n_pc = (m_id_pc4 & 32'hf000_0000) | ((m_id_instr & 32'h03ff_ffff) << 2);
                    default: n_pc = jr;
                endcase
                model_bubble();
            end else begin
                m_id_pc = m_pc; m_id_pc4 = seq_next(m_pc); m_id_instr = instr; m_id_valid = 1;
                n_pc = seq_next(m_pc);
            end
            m_pc = n_pc; m_pend = n_pend;
        end
        #1;
    endtask

    task automatic seq_step(input bit irq_in);
        step(1, 0, 0, 0, 3'b000, 0, irq_in, mem_word(m_pc));
    endtask

    task automatic ctl_step(input logic [2:0] src, input logic [31:0] jr, input bit irq_in);
        step(1, 0, 0, 0, src, jr, irq_in, mem_word(m_pc));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 0; stall = 0; ex_branch_taken = 0; ex_branch_target = 0;
        id_pcsrc = 0; jr_target = 0; irq = 0; imem_bus.imem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_addr", imem_bus.imem_addr, 32'h8000_0000);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_instr", if_id_instr, 32'h0);

        // Free-running fetch after reset
        seq_step(0);
        check("boot_valid", 32'(if_id_valid), 32'd1);
        check("boot_id_pc", if_id_pc, 32'h8000_0000);
        check("boot_addr1", imem_bus.imem_addr, 32'h8000_0004);
        seq_step(0);
        check("boot_addr2", imem_bus.imem_addr, 32'h8000_0008);
        seq_step(0);

        // j 0x40 from 0x00400004
        ctl_step(3'b011, 32'h0040_0004, 0);
        step(1, 0, 0, 0, 3'b000, 0, 0, 32'h0800_0010);
        check("j_id_pc4", if_id_pc_plus4, 32'h0040_0008);
        ctl_step(3'b010, 0, 0);
        check("j_addr", imem_bus.imem_addr, 32'h0000_0040);
        check("j_bubble_instr", if_id_instr, 32'h0);
        check("j_bubble_valid", 32'(if_id_valid), 32'd0);

        // Branch taken beats stall and a jump in ID
        seq_step(0);
        step(1, 1, 1, 32'h0040_0100, 3'b010, 0, 0, mem_word(m_pc));
        check("br_addr", imem_bus.imem_addr, 32'h0040_0100);
        check("br_bubble", 32'(if_id_valid), 32'd0);

        // Two-cycle stall at 0x00400010
        seq_step(0);
        ctl_step(3'b011, 32'h0040_000c, 0);
        seq_step(0);
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 0, 3'b000, 0, 0, mem_word(m_pc));
            check("stall_addr", imem_bus.imem_addr, 32'h0040_0010);
            check("stall_id_pc", if_id_pc, 32'h0040_000c);
        end
        seq_step(0);
        check("stall_release", imem_bus.imem_addr, 32'h0040_0014);

        // IRQ masked in kernel, taken after jr to user code
        ctl_step(3'b011, 32'h8000_0020, 0);
        seq_step(1);
        ctl_step(3'b011, 32'h0040_0000, 0);
        check("irq_kernel_pend", 32'(dbg_irq_pending), 32'd1);
        seq_step(0);
        check("irq_take_user", 32'(irq_take), 32'd1);
        check("irq_epc", if_id_pc, 32'h0040_0000);
        seq_step(0);
        check("irq_vec", imem_bus.imem_addr, 32'h8000_0004);
        check("irq_cleared", 32'(dbg_irq_pending), 32'd0);

        // Exception in kernel with IRQ pending
        seq_step(0);
        ctl_step(3'b011, 32'h8000_0010, 1);
        seq_step(0);
        ctl_step(3'b101, 0, 0);
        check("exc_vec", imem_bus.imem_addr, 32'h8000_0008);
        check("exc_pend_kept", 32'(dbg_irq_pending), 32'd1);

        // Reset mid-operation drops the pending request
        step(0, 0, 0, 0, 3'b000, 0, 1, mem_word(m_pc));
        check("midrst_pend", 32'(dbg_irq_pending), 32'd0);
        check("midrst_addr", imem_bus.imem_addr, 32'h8000_0000);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            bit          r_rst, r_st, r_br, r_irq;
            logic [2:0]  r_src;
            logic [31:0] r_jr, r_tgt;
            int          pick;
            r_rst = ($urandom_range(0, 59) != 0);
            r_st  = ($urandom_range(0, 4) == 0);
            r_br  = ($urandom_range(0, 7) == 0);
            r_irq = ($urandom_range(0, 9) == 0);
            pick  = $urandom_range(0, 9);
            r_src = (pick < 4) ? 3'b000 : (pick < 5) ? 3'b001 : (pick < 7) ? 3'b010 :
                    (pick < 9) ? 3'b011 : 3'b101;
            r_jr  = $urandom() & 32'hffff_fffc;
            r_tgt = $urandom() & 32'hffff_fffc;
            step(r_rst, r_st, r_br, r_tgt, r_src, r_jr, r_irq,
                 ($urandom_range(0, 3) == 0) ? $urandom() : mem_word(m_pc));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
